// File: rtl/keccak_padder_if.sv
// keccak_padder_if: message-stream and core-side signals of the keccak padder.
//   Msg_data/Msg_valid/Msg_last/Msg_bytes : message word from the source
//   Msg_ready                             : padder accepts a word this cycle
//   Buffer_full                           : core input buffer full
//   Din/Din_valid/Last_block              : words and completion pulse to the core
// slave = padder view, master = source/core view.
interface keccak_padder_if #(
    parameter int unsigned N = 64
);
    localparam int unsigned BW = $clog2(N / 8) + 1;

    logic [N-1:0]  Msg_data;
    logic          Msg_valid;
    logic          Msg_last;
    logic [BW-1:0] Msg_bytes;
    logic          Msg_ready;
    logic          Buffer_full;
    logic [N-1:0]  Din;
    logic          Din_valid;
    logic          Last_block;

    modport slave (
        input  Msg_data, Msg_valid, Msg_last, Msg_bytes, Buffer_full,
        output Msg_ready, Din, Din_valid, Last_block
    );

    modport master (
        output Msg_data, Msg_valid, Msg_last, Msg_bytes, Buffer_full,
        input  Msg_ready, Din, Din_valid, Last_block
    );
endinterface

// File: rtl/keccak_padder.sv
// keccak_padder: pad10*1 front end for the keccak core. Accepts a byte-granular
// message stream and emits rate-sized blocks of N-bit words, honouring the
// core's Buffer_full back-pressure, then pulses Last_block.
// Ports:
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   start_i : synchronous restart pulse (shared with the core)
//   bus     : keccak_padder_if.slave (message input, core Din/Din_valid/
//             Last_block output, Buffer_full input, Msg_ready output)
// Build option: define KECCAK_SHA3_PAD_EN for SHA-3 domain padding (first
// pad byte 0x06 instead of 0x01).
module keccak_padder #(
    parameter int unsigned N          = 64,
    parameter int unsigned RATE_WORDS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    keccak_padder_if.slave  bus
);
    localparam int unsigned NB = N / 8;
    localparam int unsigned BW = $clog2(NB) + 1;
    localparam int unsigned CW = $clog2(RATE_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] FIRST_PAD = 8'h06;
`else
    localparam logic [7:0] FIRST_PAD = 8'h01;
`endif

    localparam logic [N-1:0] FIRST_WORD = {{(N-8){1'b0}}, FIRST_PAD};
    localparam logic [N-1:0] END_WORD   = {8'h80, {(N-8){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD,
        BLK_WAIT,
        LAST
    } state_t;

    state_t        state_q;
    logic [CW-1:0] word_cnt_q;
    logic [N-1:0]  din_q;
    logic          din_valid_q;
    logic          last_block_q;
    logic          pad_pending_q;   // first pad byte not yet placed
    logic          padding_q;       // message consumed, pad words still owed
    logic          pad_done_q;      // final word of the padded message issued

    logic          msg_ready_c;
    logic          msg_fire_c;
    logic          blk_end_c;
    logic          full_last_c;
    logic [N-1:0]  last_word_c;
    logic [N-1:0]  end_mask_c;

    assign msg_ready_c = (state_q == ABSORB) && !bus.Buffer_full;
    assign msg_fire_c  = bus.Msg_valid && msg_ready_c;
    assign blk_end_c   = (word_cnt_q == LAST_IDX);
    assign full_last_c = (bus.Msg_bytes == BW'(NB));
    assign end_mask_c  = blk_end_c ? END_WORD : '0;

    // Partial final word: keep valid bytes, place first pad byte right after them.
    always_comb begin
        last_word_c = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (BW'(k) < bus.Msg_bytes) begin
                last_word_c[8*k +: 8] = bus.Msg_data[8*k +: 8];
            end else if (BW'(k) == bus.Msg_bytes) begin
                last_word_c[8*k +: 8] = FIRST_PAD;
            end
        end
    end

    // Padder FSM with registered core-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            din_q         <= '0;
            din_valid_q   <= 1'b0;
            last_block_q  <= 1'b0;
            pad_pending_q <= 1'b0;
            padding_q     <= 1'b0;
            pad_done_q    <= 1'b0;
        end else if (start_i) begin
            state_q       <= ABSORB;
            word_cnt_q    <= '0;
            din_valid_q   <= 1'b0;
            last_block_q  <= 1'b0;
            pad_pending_q <= 1'b0;
            padding_q     <= 1'b0;
            pad_done_q    <= 1'b0;
        end else begin
            din_valid_q  <= 1'b0;
            last_block_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    din_q <= '0;
                end

                ABSORB: begin
                    if (msg_fire_c) begin
                        din_valid_q <= 1'b1;
                        word_cnt_q  <= blk_end_c ? '0 : word_cnt_q + CW'(1);
                        if (!bus.Msg_last) begin
                            din_q   <= bus.Msg_data;
                            state_q <= blk_end_c ? BLK_WAIT : ABSORB;
                        end else if (full_last_c) begin
                            // Whole word is data; pad byte goes into a later word.
                            din_q         <= bus.Msg_data;
                            pad_pending_q <= 1'b1;
                            padding_q     <= 1'b1;
                            state_q       <= blk_end_c ? BLK_WAIT : PAD;
                        end else begin
                            din_q <= last_word_c | end_mask_c;
                            if (blk_end_c) begin
                                pad_done_q <= 1'b1;
                                state_q    <= BLK_WAIT;
                            end else begin
                                padding_q <= 1'b1;
                                state_q   <= PAD;
                            end
                        end
                    end
                end

                PAD: begin
                    if (!bus.Buffer_full) begin
                        din_valid_q   <= 1'b1;
                        din_q         <= (pad_pending_q ? FIRST_WORD : '0) | end_mask_c;
                        pad_pending_q <= 1'b0;
                        word_cnt_q    <= blk_end_c ? '0 : word_cnt_q + CW'(1);
                        if (blk_end_c) begin
                            pad_done_q <= 1'b1;
                            state_q    <= BLK_WAIT;
                        end
                    end
                end

                BLK_WAIT: begin
                    if (!bus.Buffer_full) begin
                        if (pad_done_q) begin
                            last_block_q <= 1'b1;
                            state_q      <= LAST;
                        end else if (padding_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q <= ABSORB;
                        end
                    end
                end

                LAST: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Msg_ready  = msg_ready_c;
    assign bus.Din        = din_q;
    assign bus.Din_valid  = din_valid_q;
    assign bus.Last_block = last_block_q;

endmodule
